array_drain_deskew: RTL and testbench
=====================================

# array_drain_deskew

Drain-side collector for the MAC-based systolic cube array. It sits below the bottom PE row and captures the skewed accumulated sums that leave each column one cycle after its left neighbour. It realigns them into full rows, requantizes each sum from ACC_WIDTH to OUT_WIDTH with shift, round and saturate, and queues rows in a small FIFO behind a valid/ready interface. The array cannot stall, so a full FIFO drops the row and raises a sticky overflow flag.

## Interface
- COLS, 4, array columns; column j result lags column 0 by j cycles
- ACC_WIDTH, 24, signed partial-sum width from the array
- OUT_WIDTH, 8, signed output element width
- DEPTH, 4, FIFO depth in rows (power of two, >= 2)
- ROWS_PER_TILE, 4, rows per output tile, used for o_last framing
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous flush of the pipeline, FIFO, counters and overflow flag
- i_valid  in  1  column-0 sum valid this cycle; column j is implicitly valid j cycles later
- i_y_p  in  COLS*ACC_WIDTH  bottom-row sums; column j occupies bits [j*ACC_WIDTH +: ACC_WIDTH]
- i_shift  in  5  right-shift amount; quasi-static, changed only while the block is idle
- i_ready  in  1  downstream ready
- o_valid  out  1  FIFO head row valid
- o_data  out  COLS*OUT_WIDTH  head row; column j occupies [j*OUT_WIDTH +: OUT_WIDTH]
- o_last  out  1  head row is the last row of a tile
- o_overflow  out  1  sticky; a row was dropped

## Operation
- Deskew: column j passes through COLS-j register stages. i_valid passes through COLS stages. All columns of one row land in the aligned register on the same edge.
- Requant, one register stage, per column with s = min(i_shift, ACC_WIDTH-1):
  - If s > 0, compute r = (x + (1 << (s-1))) >>> s. The addition is done in ACC_WIDTH+1 bits, so there is no wrap.
  - If s = 0, r = x.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Tile counter, range 0..ROWS_PER_TILE-1:
  - Advances on every requantized row, including dropped rows, so tile framing survives drops.
  - The row is tagged last when the counter equals ROWS_PER_TILE-1; the counter then wraps to 0.
- FIFO:
  - Entries are {last, data}, DEPTH entries, with read and write pointers one bit wider than the address.
  - Write when a requantized row is valid and either the FIFO is not full or a pop happens on the same edge. A simultaneous push and pop while full succeeds.
  - If the FIFO is full with no pop, the row is dropped and o_overflow is set.
  - Pop on o_valid && i_ready.
- o_valid = FIFO not empty. o_data and o_last show the head entry and hold stable while o_valid && !i_ready.
- i_clear:
  - Zeroes all deskew valids, the tile counter and both pointers, and clears o_overflow. Data registers need not be cleared.
  - Takes priority over a simultaneous write or pop on the same edge.
- Reset: the same state as i_clear, asynchronous. After reset: o_valid=0, o_data=0, o_last=0, o_overflow=0.

## Timing
- i_valid high at edge E (column 0 sampled there):
  - Aligned row is registered at edge E+COLS-1.
  - Requantized row is registered at E+COLS.
  - FIFO write happens at E+COLS+1.
  - o_valid is high after edge E+COLS+1. Latency is COLS+1 edges; it is 5 with COLS=4.
- Full throughput: one row per cycle in and out while i_ready=1. Back-to-back i_valid gives back-to-back o_valid with no bubbles.
- An empty FIFO with a simultaneous push and pop is impossible, because there is no fall-through path. o_valid rises only the edge after a write.
- o_overflow rises on the edge of the dropped write and stays high until i_clear or reset.
- A reset mid-stream discards every in-flight row. Rows whose column-0 was sampled before reset never appear.

## Test plan
- Skew alignment, COLS=4, shift 0:
  - Stimulus: column j = 10+j, sampled at E+j; i_valid at E only.
  - Required: one row {13,12,11,10} (column 3 down to 0) with o_valid high after E+5, and o_last=0.
- Requant, shift 4:
  - Inputs 40, 24, -24, 5000, -5000.
  - Required outputs: 3, 2, -1, 127 (saturated), -128 (saturated). Note -24 → (-24+8)>>>4 = -1.
- Shift clamp: i_shift=31 with ACC_WIDTH=24; input 2^23-1 → 1. Input -2^23 → -1 (i.e. (-2^23 + 2^22) >>> 23).
- Backpressure and overflow, DEPTH=4:
  - Stimulus: i_ready=0 while 6 consecutive rows are sent.
  - Required: 4 rows stored, rows 5-6 dropped, o_overflow=1.
  - Then i_ready=1: 4 rows out in order. The 4th row out carries o_last=1 (tile counter counted 4), and o_overflow stays 1 until i_clear.
- Full with simultaneous pop: FIFO full, i_ready=1 on the same edge as a new write → no drop, occupancy stays 4, o_overflow stays 0.
- Reset/clear mid-stream:
  - Stimulus: assert rst_n=0 two cycles after i_valid, then release.
  - Required: o_valid=0, o_data=0, o_last=0, o_overflow=0 immediately; no row appears afterwards.
  - The same stimulus using i_clear gives the same result with no row output.

Source files
------------

// File: rtl/array_drain_deskew.sv
// Drain-side collector for the systolic array: deskews the staggered column sums,
// requantizes them with shift/round/saturate, and queues rows in a small drop-on-full FIFO.
module array_drain_deskew #(
  parameter int COLS          = 4,
  parameter int ACC_WIDTH     = 24,
  parameter int OUT_WIDTH     = 8,
  parameter int DEPTH         = 4,
  parameter int ROWS_PER_TILE = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic                          i_valid,
  input  logic [COLS*ACC_WIDTH-1:0]     i_y_p,
  input  logic [4:0]                    i_shift,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [COLS*OUT_WIDTH-1:0]     o_data,
  output logic                          o_last,
  output logic                          o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
  localparam logic [TW-1:0] TILE_LAST = TW'(ROWS_PER_TILE - 1);
  localparam int RW = COLS*OUT_WIDTH + 1;
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = ~SAT_HI;

  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [4:0] sh);
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] one;
    logic signed [ACC_WIDTH:0] r;
    int s;
    s   = (int'(sh) > ACC_WIDTH-1) ? ACC_WIDTH-1 : int'(sh);
    ext = {x[ACC_WIDTH-1], x};
    one = (ACC_WIDTH+1)'(1);
    if (s > 0) r = (ext + (one <<< (s-1))) >>> s;
    else       r = ext;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    return r[OUT_WIDTH-1:0];
  endfunction

  // Deskew: column j is sampled j cycles late, so it gets COLS-j stages.
  logic [COLS-1:0]      dv;
  logic [ACC_WIDTH-1:0] aligned [COLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv <= '0;
    end else if (i_clear) begin
      dv <= '0;
    end else begin
      dv[0] <= i_valid;
      for (int k = 1; k < COLS; k++) dv[k] <= dv[k-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [ACC_WIDTH-1:0] pipe [COLS-j];
    always_ff @(posedge clk) begin
      pipe[0] <= i_y_p[j*ACC_WIDTH +: ACC_WIDTH];
      for (int k = 1; k < COLS-j; k++) pipe[k] <= pipe[k-1];
    end
    assign aligned[j] = pipe[COLS-1-j];
  end

  logic [COLS*OUT_WIDTH-1:0] q_data;
  logic                      q_valid;
  logic                      q_last;
  logic [TW-1:0]             tile_cnt;

  always_ff @(posedge clk) begin
    for (int j = 0; j < COLS; j++)
      q_data[j*OUT_WIDTH +: OUT_WIDTH] <= requant(aligned[j], i_shift);
  end

  // Tile framing counts every requantized row, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid  <= 1'b0;
      q_last   <= 1'b0;
      tile_cnt <= '0;
    end else if (i_clear) begin
      q_valid  <= 1'b0;
      q_last   <= 1'b0;
      tile_cnt <= '0;
    end else begin
      q_valid <= dv[COLS-1];
      if (dv[COLS-1]) begin
        q_last   <= (tile_cnt == TILE_LAST);
        tile_cnt <= (tile_cnt == TILE_LAST) ? '0 : tile_cnt + TW'(1);
      end
    end
  end

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] head;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && i_ready;
  assign push  = q_valid && (!full || pop);
  assign drop  = q_valid && full && !pop;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !i_clear) mem[wr_ptr[AW-1:0]] <= {q_last, q_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) o_overflow <= 1'b1;
    end
  end

  // Head is masked while empty so the outputs read zero after reset or clear.
  assign o_valid = !empty;
  assign o_data  = empty ? '0 : head[COLS*OUT_WIDTH-1:0];
  assign o_last  = !empty && head[RW-1];

endmodule

// File: tb/tb_array_drain_deskew.sv
// Randomized scoreboard bench for array_drain_deskew with an arithmetic reference model.
module tb_array_drain_deskew;

  localparam int COLS = 4;
  localparam int AWD  = 24;
  localparam int OW   = 8;
  localparam int DEPTH = 4;
  localparam int RPT  = 4;
  localparam int LAT  = COLS + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_clear = 1'b0;
  logic                  i_valid = 1'b0;
  logic [COLS*AWD-1:0]   i_y_p = '0;
  logic [4:0]            i_shift = '0;
  logic                  i_ready = 1'b0;
  logic                  o_valid;
  logic [COLS*OW-1:0]    o_data;
  logic                  o_last;
  logic                  o_overflow;

  array_drain_deskew #(.COLS(COLS), .ACC_WIDTH(AWD), .OUT_WIDTH(OW), .DEPTH(DEPTH),
                       .ROWS_PER_TILE(RPT)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .i_y_p(i_y_p),
    .i_shift(i_shift), .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data),
    .o_last(o_last), .o_overflow(o_overflow));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_pops = 0;

  typedef struct {
    int                 arrival;
    logic [COLS*OW-1:0] data;
    logic               last;
  } exp_t;

  exp_t pend[$];
  exp_t exp_q[$];
  bit   m_ovf = 1'b0;
  int   m_tile = 0;
  int   last_t = 0;
  logic [COLS*AWD-1:0] sched [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [OW-1:0] ref_q(input longint x, input int sh);
    longint r;
    int s;
    s = (sh > AWD-1) ? AWD-1 : sh;
    if (s > 0) r = (x + (longint'(1) << (s-1))) >>> s;
    else       r = x;
    if (r > 2**(OW-1) - 1) r = 2**(OW-1) - 1;
    if (r < -(2**(OW-1)))  r = -(2**(OW-1));
    return OW'(r);
  endfunction

  function automatic logic [COLS*AWD-1:0] mk4(input int a, input int b, input int c, input int d);
    logic [COLS*AWD-1:0] v;
    v = {AWD'(d), AWD'(c), AWD'(b), AWD'(a)};
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Schedules a row for column-0 sampling at edge t and records its expected output.
  task automatic issue(input logic [COLS*AWD-1:0] row, output int t);
    exp_t e;
    logic signed [AWD-1:0] xs;
    longint x;
    t = (last_t >= cyc + 2) ? last_t + 1 : cyc + 2;
    for (int j = 0; j < COLS; j++) begin
      xs = row[j*AWD +: AWD];
      x  = xs;
      e.data[j*OW +: OW] = ref_q(x, int'(i_shift));
    end
    e.last    = (m_tile == RPT - 1);
    e.arrival = t + LAT;
    m_tile    = (m_tile + 1) % RPT;
    pend.push_back(e);
    sched[t] = row;
    last_t   = t;
  endtask

  task automatic flush_model();
    pend.delete();
    exp_q.delete();
    sched.delete();
    m_ovf  = 1'b0;
    m_tile = 0;
    last_t = 0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    i_ready = 1'b1;
    while ((exp_q.size() != 0 || pend.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d rows still expected after %0d cycles", exp_q.size() + pend.size(), budget);
    end
  endtask

  task automatic wait_cyc(input int target);
    int k;
    k = 0;
    while (cyc < target && k < 200) begin
      step(1);
      k++;
    end
  endtask

  task automatic expect_head(input int t, input logic [COLS*OW-1:0] d, input string name);
    wait_cyc(t + LAT);
    check({name, "_valid"}, o_valid, 1'b1);
    check({name, "_data"}, o_data, d);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    sched.delete();
    m_tile = 0;
    last_t = 0;
    step(1);
    i_clear = 1'b0;
  endtask

  // Column j of the bus carries the row whose column 0 was sampled j edges earlier.
  initial begin
    logic [COLS*AWD-1:0] r;
    int t;
    forever begin
      @(posedge clk);
      #1;
      t = cyc + 1;
      i_valid = sched.exists(t);
      for (int j = 0; j < COLS; j++) begin
        if (sched.exists(t - j)) begin
          r = sched[t - j];
          i_y_p[j*AWD +: AWD] = r[j*AWD +: AWD];
        end else begin
          i_y_p[j*AWD +: AWD] = AWD'($urandom);
        end
      end
    end
  end

  // Monitor: compares the presented head, then applies the upcoming edge to the model FIFO.
  initial begin
    int  n;
    int  occ;
    bit  pop;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = cyc + 1;
        check("o_valid", o_valid, exp_q.size() != 0);
        check("o_overflow", o_overflow, m_ovf);
        if (exp_q.size() != 0 && o_valid) begin
          check("o_data", o_data, exp_q[0].data);
          check("o_last", o_last, exp_q[0].last);
        end
        if (o_valid && i_ready) dut_pops++;
        if (i_clear) begin
          pend.delete();
          exp_q.delete();
          m_ovf = 1'b0;
        end else begin
          occ = exp_q.size();
          pop = (occ != 0) && i_ready;
          if (pop) void'(exp_q.pop_front());
          while (pend.size() != 0 && pend[0].arrival <= n) begin
            if (pend[0].arrival < n) begin
              n_tests++;
              n_fail++;
              $display("FAIL model_order: row due at %0d seen at %0d", pend[0].arrival, n);
            end else if (occ < DEPTH || pop) begin
              exp_q.push_back(pend[0]);
            end else begin
              m_ovf = 1'b1;
            end
            void'(pend.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t;
    int p0;
    logic [COLS*AWD-1:0] row;

    #3;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_data", o_data, '0);
    check("rst_o_last", o_last, 1'b0);
    check("rst_o_overflow", o_overflow, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Skew alignment, shift 0
    i_shift = 5'd0;
    i_ready = 1'b1;
    issue(mk4(10, 11, 12, 13), t0);
    wait_cyc(t0 + LAT - 1);
    check("skew_early_valid", o_valid, 1'b0);
    expect_head(t0, {8'd13, 8'd12, 8'd11, 8'd10}, "skew");
    check("skew_last", o_last, 1'b0);
    drain(50);

    // Requant with shift 4, incl. rounding toward +inf and saturation
    i_shift = 5'd4;
    issue(mk4(40, 24, -24, 5000), t0);
    step(1);
    issue(mk4(-5000, 0, 7, 8), t1);
    expect_head(t0, {8'h7f, 8'hff, 8'h02, 8'h03}, "rq4_a");
    expect_head(t1, {8'h01, 8'h00, 8'h00, 8'h80}, "rq4_b");
    drain(50);

    // Shift clamp to ACC_WIDTH-1
    i_shift = 5'd31;
    issue(mk4(2**23 - 1, -(2**23), 0, -1), t0);
    expect_head(t0, {8'h00, 8'h00, 8'hff, 8'h01}, "clamp");
    drain(50);

    // Randomized traffic with random backpressure and gaps
    for (int b = 0; b < 12; b++) begin
      drain(100);
      i_shift = 5'($urandom_range(0, 31));
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < COLS; j++) begin
          if ($urandom_range(0, 1) == 0)
            row[j*AWD +: AWD] = AWD'($urandom);
          else
            row[j*AWD +: AWD] = AWD'($signed($urandom_range(0, 2000)) - 1000);
        end
        issue(row, t);
        i_ready = ($urandom_range(0, 3) != 0);
        step(1 + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0));
      end
    end
    drain(100);
    do_clear();
    step(1);
    check("clear_ovf", o_overflow, 1'b0);

    // Backpressure: 6 rows into a 4-deep FIFO
    i_shift = 5'd0;
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(mk4(i, i + 1, -i, 100 + i), t);
      step(1);
    end
    step(LAT + 2);
    check("bp_overflow", o_overflow, 1'b1);
    check("bp_valid", o_valid, 1'b1);
    p0 = dut_pops;
    drain(50);
    step(2);
    check("bp_rows_out", dut_pops - p0, 4);
    check("bp_ovf_sticky", o_overflow, 1'b1);
    do_clear();
    step(1);
    check("bp_ovf_cleared", o_overflow, 1'b0);

    // Full FIFO with pop on the same edge as a new write
    i_ready = 1'b0;
    issue(mk4(1, 2, 3, 4), t0);
    step(1);
    for (int i = 1; i < 5; i++) begin
      issue(mk4(5 * i, 6, 7, 8), t);
      step(1);
    end
    wait_cyc(t0 + 8);
    i_ready = 1'b1;
    step(1);
    i_ready = 1'b0;
    step(2);
    check("simul_no_ovf", o_overflow, 1'b0);
    p0 = dut_pops;
    drain(50);
    step(2);
    check("simul_occupancy", dut_pops - p0, 4);

    // Reset mid-stream after an overflow
    do_clear();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(mk4(i, 2, 3, 4), t);
      step(1);
    end
    step(LAT + 2);
    issue(mk4(77, 78, 79, 80), t0);
    wait_cyc(t0 + 2);
    rst_n = 1'b0;
    flush_model();
    #1;
    check("mrst_o_valid", o_valid, 1'b0);
    check("mrst_o_data", o_data, '0);
    check("mrst_o_last", o_last, 1'b0);
    check("mrst_o_overflow", o_overflow, 1'b0);
    step(2);
    rst_n = 1'b1;
    i_ready = 1'b1;
    p0 = dut_pops;
    step(12);
    check("mrst_no_row", dut_pops - p0, 0);

    // Clear mid-stream after an overflow
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(mk4(i, 9, 9, 9), t);
      step(1);
    end
    step(LAT + 2);
    check("mclr_pre_ovf", o_overflow, 1'b1);
    issue(mk4(55, 56, 57, 58), t0);
    wait_cyc(t0 + 1);
    do_clear();
    check("mclr_o_valid", o_valid, 1'b0);
    check("mclr_o_data", o_data, '0);
    check("mclr_o_last", o_last, 1'b0);
    check("mclr_o_overflow", o_overflow, 1'b0);
    i_ready = 1'b1;
    p0 = dut_pops;
    step(12);
    check("mclr_no_row", dut_pops - p0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
